// File: rtl/ex_hazard_stage.sv
// Execute stage, EX/MEM pipeline register and data-hazard/forwarding unit.
// Resolves operands and branches, latches results for MEM, and drives stall/forward controls.
module ex_hazard_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RET_ADDR,
  input  logic [7:0]  TA_IN,
  input  logic [31:0] FPA,
  input  logic [31:0] FPB,
  input  logic [20:0] IM,
  input  logic [2:0]  COND,
  input  logic [4:0]  IDR,
  input  logic [1:0]  PSW_LE_RE,
  input  logic        B,
  input  logic        UB,
  input  logic [2:0]  SOH_OP,
  input  logic [3:0]  ALU_OP,
  input  logic [3:0]  RAM_CTRL,
  input  logic        L,
  input  logic        RF_LE,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  input  logic [1:0]  ID_SR,
  input  logic [4:0]  WB_RD,
  input  logic        WB_RF_LE,
  output logic        EX_J,
  output logic [7:0]  TARGET_ADDRESS,
  output logic [31:0] EX_OUT,
  output logic [31:0] EX_OUT_Q,
  output logic [31:0] EX_DI_Q,
  output logic [4:0]  EX_RD_Q,
  output logic        L_Q,
  output logic        RF_LE_Q,
  output logic [3:0]  RAM_CTRL_Q,
  output logic        NOP,
  output logic        LE,
  output logic [1:0]  A_S,
  output logic [1:0]  B_S
);

  logic [31:0] w_opB;
  logic [32:0] w_sum;
  logic [31:0] w_alu;
  logic        w_cin;
  logic        w_c;
  logic        w_v;
  logic        w_z;
  logic        w_n;
  logic        w_cond;
  logic        r_pswC;
  logic [31:0] r_exOutQ;
  logic [31:0] r_exDiQ;
  logic [4:0]  r_exRdQ;
  logic        r_lQ;
  logic        r_rfLeQ;
  logic [3:0]  r_ramCtrlQ;

  always_comb begin
    case (SOH_OP)
      3'b000:  w_opB = FPB;
      3'b001:  w_opB = {{21{IM[10]}}, IM[10:0]};
      3'b010:  w_opB = {{18{IM[13]}}, IM[13:0]};
      3'b011:  w_opB = {IM[20:0], 11'b0};
      3'b100:  w_opB = {27'b0, IM[4:0]};
      default: w_opB = 32'b0;
    endcase
  end

  // Subtraction is done as A + ~B + 1 so the carry-out reads as "no borrow".
  always_comb begin
    w_cin = PSW_LE_RE[0] & r_pswC;
    w_sum = 33'b0;
    w_alu = 32'b0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALU_OP)
      4'h0: begin
        w_sum = {1'b0, FPA} + {1'b0, w_opB};
        w_alu = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (FPA[31] == w_opB[31]) && (w_alu[31] != FPA[31]);
      end
      4'h1: begin
        w_sum = {1'b0, FPA} + {1'b0, w_opB} + {32'b0, w_cin};
        w_alu = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (FPA[31] == w_opB[31]) && (w_alu[31] != FPA[31]);
      end
      4'h2: begin
        w_sum = {1'b0, FPA} + {1'b0, ~w_opB} + 33'd1;
        w_alu = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (FPA[31] != w_opB[31]) && (w_alu[31] != FPA[31]);
      end
      4'h3: begin
        w_sum = {1'b0, w_opB} + {1'b0, ~FPA} + 33'd1;
        w_alu = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (FPA[31] != w_opB[31]) && (w_alu[31] != w_opB[31]);
      end
      4'h4:    w_alu = FPA & w_opB;
      4'h5:    w_alu = FPA | w_opB;
      4'h6:    w_alu = FPA ^ w_opB;
      4'h7:    w_alu = FPA & ~w_opB;
      4'h8:    w_alu = w_opB;
      4'h9:    w_alu = FPA;
      4'hA:    w_alu = FPA << w_opB[4:0];
      4'hB:    w_alu = FPA >> w_opB[4:0];
      4'hC:    w_alu = $unsigned($signed(FPA) >>> w_opB[4:0]);
      default: w_alu = 32'b0;
    endcase
    w_z = (w_alu == 32'b0);
    w_n = w_alu[31];
  end

  always_comb begin
    case (COND)
      3'b000:  w_cond = 1'b0;
      3'b001:  w_cond = w_z;
      3'b010:  w_cond = w_n ^ w_v;
      3'b011:  w_cond = (w_n ^ w_v) | w_z;
      3'b100:  w_cond = ~w_c;
      3'b101:  w_cond = ~w_c | w_z;
      3'b110:  w_cond = w_v;
      default: w_cond = w_alu[0];
    endcase
  end

  assign EX_J           = UB | (B & w_cond);
  assign TARGET_ADDRESS = TA_IN;
  assign EX_OUT         = (UB | B) ? {24'b0, RET_ADDR} : w_alu;

  // Forwarding priority is youngest producer first: EX, then MEM, then WB.
  always_comb begin
    A_S = 2'b00;
    if (RA != 5'd0) begin
      if (RF_LE && (IDR == RA))            A_S = 2'b01;
      else if (r_rfLeQ && (r_exRdQ == RA)) A_S = 2'b10;
      else if (WB_RF_LE && (WB_RD == RA))  A_S = 2'b11;
    end
    B_S = 2'b00;
    if (RB != 5'd0) begin
      if (RF_LE && (IDR == RB))            B_S = 2'b01;
      else if (r_rfLeQ && (r_exRdQ == RB)) B_S = 2'b10;
      else if (WB_RF_LE && (WB_RD == RB))  B_S = 2'b11;
    end
  end

  always_comb begin
    NOP = L & RF_LE & (IDR != 5'd0) &
          ((ID_SR[0] & (RA == IDR)) | (ID_SR[1] & (RB == IDR)));
    LE  = ~NOP;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_exOutQ   <= 32'b0;
      r_exDiQ    <= 32'b0;
      r_exRdQ    <= 5'b0;
      r_lQ       <= 1'b0;
      r_rfLeQ    <= 1'b0;
      r_ramCtrlQ <= 4'b0;
      r_pswC     <= 1'b0;
    end else begin
      r_exOutQ   <= EX_OUT;
      r_exDiQ    <= FPB;
      r_exRdQ    <= IDR;
      r_lQ       <= L;
      r_rfLeQ    <= RF_LE;
      r_ramCtrlQ <= RAM_CTRL;
      if (PSW_LE_RE[1]) r_pswC <= w_c;
    end
  end

  assign EX_OUT_Q   = r_exOutQ;
  assign EX_DI_Q    = r_exDiQ;
  assign EX_RD_Q    = r_exRdQ;
  assign L_Q        = r_lQ;
  assign RF_LE_Q    = r_rfLeQ;
  assign RAM_CTRL_Q = r_ramCtrlQ;

endmodule

// File: tb/tb_ex_hazard_stage.sv
// Self-checking bench for ex_hazard_stage: an arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_ex_hazard_stage;

  logic        CLK, RST;
  logic [7:0]  RET_ADDR, TA_IN;
  logic [31:0] FPA, FPB;
  logic [20:0] IM;
  logic [2:0]  COND, SOH_OP;
  logic [4:0]  IDR, RA, RB, WB_RD;
  logic [1:0]  PSW_LE_RE, ID_SR;
  logic        B, UB, L, RF_LE, WB_RF_LE;
  logic [3:0]  ALU_OP, RAM_CTRL;
  logic        EX_J, L_Q, RF_LE_Q, NOP, LE;
  logic [7:0]  TARGET_ADDRESS;
  logic [31:0] EX_OUT, EX_OUT_Q, EX_DI_Q;
  logic [4:0]  EX_RD_Q;
  logic [3:0]  RAM_CTRL_Q;
  logic [1:0]  A_S, B_S;

  int checks = 0;
  int failures = 0;
  logic checkEn = 1'b0;

  ex_hazard_stage dut (
    .CLK(CLK), .RST(RST), .RET_ADDR(RET_ADDR), .TA_IN(TA_IN), .FPA(FPA), .FPB(FPB),
    .IM(IM), .COND(COND), .IDR(IDR), .PSW_LE_RE(PSW_LE_RE), .B(B), .UB(UB),
    .SOH_OP(SOH_OP), .ALU_OP(ALU_OP), .RAM_CTRL(RAM_CTRL), .L(L), .RF_LE(RF_LE),
    .RA(RA), .RB(RB), .ID_SR(ID_SR), .WB_RD(WB_RD), .WB_RF_LE(WB_RF_LE),
    .EX_J(EX_J), .TARGET_ADDRESS(TARGET_ADDRESS), .EX_OUT(EX_OUT), .EX_OUT_Q(EX_OUT_Q),
    .EX_DI_Q(EX_DI_Q), .EX_RD_Q(EX_RD_Q), .L_Q(L_Q), .RF_LE_Q(RF_LE_Q),
    .RAM_CTRL_Q(RAM_CTRL_Q), .NOP(NOP), .LE(LE), .A_S(A_S), .B_S(B_S)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] exOut;
    logic        exJ;
    logic        carry;
    logic        nop;
    logic [1:0]  aS;
    logic [1:0]  bS;
  } exp_t;

  // Model state: what the pipeline register and the carry flag must hold.
  logic [31:0] mOutQ, mDiQ;
  logic [4:0]  mRdQ;
  logic        mLQ, mRfLeQ, mPswC;
  logic [3:0]  mRamQ;

  function automatic logic [1:0] fwdSel(logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (RF_LE && IDR == r) return 2'b01;
    if (mRfLeQ && mRdQ == r) return 2'b10;
    if (WB_RF_LE && WB_RD == r) return 2'b11;
    return 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t e;
    longint unsigned ua, ub, u;
    longint sa, sb, s, cin;
    logic [31:0] opB, res;
    logic c, v, z, n, cnd;
    case (SOH_OP)
      3'd0: opB = FPB;
      3'd1: opB = 32'(longint'($signed(IM[10:0])));
      3'd2: opB = 32'(longint'($signed(IM[13:0])));
      3'd3: opB = 32'(longint'(IM) * 2048);
      3'd4: opB = 32'(IM % 32);
      default: opB = 0;
    endcase
    ua = longint'(FPA); ub = longint'(opB);
    sa = longint'($signed(FPA)); sb = longint'($signed(opB));
    cin = (PSW_LE_RE[0] && mPswC) ? 1 : 0;
    c = 0; v = 0; s = 0; u = 0;
    case (ALU_OP)
      4'd0: begin u = ua + ub; c = (u >> 32) != 0; s = sa + sb; end
      4'd1: begin u = ua + ub + longint'(cin); c = (u >> 32) != 0; s = sa + sb + cin; end
      4'd2: begin u = ua - ub; c = ua >= ub; s = sa - sb; end
      4'd3: begin u = ub - ua; c = ub >= ua; s = sb - sa; end
      4'd4: u = ua & ub;
      4'd5: u = ua | ub;
      4'd6: u = ua ^ ub;
      4'd7: u = ua & ~ub;
      4'd8: u = ub;
      4'd9: u = ua;
      4'd10: u = ua * (64'd1 << (ub % 32));
      4'd11: u = ua / (64'd1 << (ub % 32));
      4'd12: u = longint'(sa >>> (ub % 32));
      default: u = 0;
    endcase
    if (ALU_OP <= 4'd3) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    res = u[31:0];
    z = (res == 0); n = res[31];
    case (COND)
      3'd0: cnd = 0;
      3'd1: cnd = z;
      3'd2: cnd = n != v;
      3'd3: cnd = (n != v) || z;
      3'd4: cnd = !c;
      3'd5: cnd = !c || z;
      3'd6: cnd = v;
      default: cnd = res[0];
    endcase
    e.exJ = UB || (B && cnd);
    e.exOut = (UB || B) ? 32'(RET_ADDR) : res;
    e.carry = c;
    e.nop = L && RF_LE && IDR != 0 &&
            ((ID_SR[0] && RA == IDR) || (ID_SR[1] && RB == IDR));
    e.aS = fwdSel(RA);
    e.bS = fwdSel(RB);
    return e;
  endfunction

  always @(posedge CLK or negedge RST) begin
    exp_t e;
    if (!RST) begin
      mOutQ <= 0; mDiQ <= 0; mRdQ <= 0; mLQ <= 0; mRfLeQ <= 0; mRamQ <= 0; mPswC <= 0;
    end else begin
      e = model();
      mOutQ <= e.exOut; mDiQ <= FPB; mRdQ <= IDR; mLQ <= L; mRfLeQ <= RF_LE; mRamQ <= RAM_CTRL;
      if (PSW_LE_RE[1]) mPswC <= e.carry;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (checkEn) begin
      e = model();
      checkOutput("m_EX_OUT", EX_OUT, e.exOut);
      checkOutput("m_EX_J", 32'(EX_J), 32'(e.exJ));
      checkOutput("m_TA", 32'(TARGET_ADDRESS), 32'(TA_IN));
      checkOutput("m_NOP", 32'(NOP), 32'(e.nop));
      checkOutput("m_LE", 32'(LE), 32'(!e.nop));
      checkOutput("m_A_S", 32'(A_S), 32'(e.aS));
      checkOutput("m_B_S", 32'(B_S), 32'(e.bS));
      checkOutput("m_EX_OUT_Q", EX_OUT_Q, mOutQ);
      checkOutput("m_EX_DI_Q", EX_DI_Q, mDiQ);
      checkOutput("m_EX_RD_Q", 32'(EX_RD_Q), 32'(mRdQ));
      checkOutput("m_L_Q", 32'(L_Q), 32'(mLQ));
      checkOutput("m_RF_LE_Q", 32'(RF_LE_Q), 32'(mRfLeQ));
      checkOutput("m_RAM_Q", 32'(RAM_CTRL_Q), 32'(mRamQ));
    end
  end

  task automatic clearInputs();
    RET_ADDR = 0; TA_IN = 0; FPA = 0; FPB = 0; IM = 0; COND = 0; IDR = 0;
    PSW_LE_RE = 0; B = 0; UB = 0; SOH_OP = 0; ALU_OP = 0; RAM_CTRL = 0;
    L = 0; RF_LE = 0; RA = 0; RB = 0; ID_SR = 0; WB_RD = 0; WB_RF_LE = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [20:0] im,
                               input logic [2:0] soh, input logic [3:0] alu, input logic [2:0] cnd,
                               input logic br, input logic [31:0] expOut, input logic expJ);
    clearInputs();
    FPA = a; FPB = b; IM = im; SOH_OP = soh; ALU_OP = alu; COND = cnd; B = br;
    RET_ADDR = 8'h3C;
    #2;
    checkOutput("vec_EX_OUT", EX_OUT, expOut);
    checkOutput("vec_EX_J", 32'(EX_J), 32'(expJ));
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b0;
    clearInputs();
    #3;
    checkOutput("rst_EX_OUT_Q", EX_OUT_Q, 32'h0);
    checkOutput("rst_RF_LE_Q", 32'(RF_LE_Q), 32'h0);
    #4 RST = 1'b1;
    checkEn = 1'b1;
    step();

    // Add and its one-cycle capture
    FPA = 5; FPB = 3; IDR = 3; RF_LE = 1;
    #2 checkOutput("add_EX_OUT", EX_OUT, 32'd8);
    step();
    checkOutput("add_EX_OUT_Q", EX_OUT_Q, 32'd8);
    checkOutput("add_EX_RD_Q", 32'(EX_RD_Q), 32'd3);
    checkOutput("add_RF_LE_Q", 32'(RF_LE_Q), 32'd1);

    // Conditional branch taken / not taken, then unconditional jump
    clearInputs();
    B = 1; COND = 3'b001; ALU_OP = 4'b0010; FPA = 7; FPB = 7; TA_IN = 8'h20;
    #2 checkOutput("br_EX_J", 32'(EX_J), 32'd1);
    checkOutput("br_TA", 32'(TARGET_ADDRESS), 32'h20);
    FPB = 6;
    #1 checkOutput("br_nt_EX_J", 32'(EX_J), 32'd0);
    step();
    clearInputs();
    UB = 1; RET_ADDR = 8'h14;
    #2 checkOutput("ub_EX_J", 32'(EX_J), 32'd1);
    checkOutput("ub_EX_OUT", EX_OUT, 32'h14);
    step();

    // Forward priority EX > MEM > WB > register file
    clearInputs();
    IDR = 2; RF_LE = 1;
    step();
    RA = 2; WB_RD = 2; WB_RF_LE = 1;
    #2 checkOutput("fwd_ex", 32'(A_S), 32'b01);
    RF_LE = 0;
    #1 checkOutput("fwd_mem", 32'(A_S), 32'b10);
    step();
    #1 checkOutput("fwd_wb", 32'(A_S), 32'b11);
    RA = 0;
    #1 checkOutput("fwd_none", 32'(A_S), 32'b00);
    step();

    // Load-use stall alongside EX forward
    clearInputs();
    L = 1; RF_LE = 1; IDR = 4; RB = 4; ID_SR = 2'b10;
    #2 checkOutput("lu_NOP", 32'(NOP), 32'd1);
    checkOutput("lu_LE", 32'(LE), 32'd0);
    checkOutput("lu_B_S", 32'(B_S), 32'b01);
    ID_SR = 2'b00;
    #1 checkOutput("lu_off_NOP", 32'(NOP), 32'd0);
    checkOutput("lu_off_LE", 32'(LE), 32'd1);
    step();

    // Carry chain through PSW.C
    clearInputs();
    FPA = 32'hFFFF_FFFF; FPB = 1; PSW_LE_RE = 2'b10;
    #2 checkOutput("cc_EX_OUT", EX_OUT, 32'h0);
    step();
    clearInputs();
    ALU_OP = 4'b0001; PSW_LE_RE = 2'b01;
    #2 checkOutput("adc_EX_OUT", EX_OUT, 32'h1);
    PSW_LE_RE = 2'b00;
    #1 checkOutput("adc_nocin", EX_OUT, 32'h0);
    step();

    // Operand select, ALU functions and branch conditions
    applyStimulus(0, 0, 21'h0007FF, 3'd1, 4'h8, 3'd0, 0, 32'hFFFF_FFFF, 0);
    applyStimulus(0, 0, 21'h002000, 3'd2, 4'h8, 3'd0, 0, 32'hFFFF_E000, 0);
    applyStimulus(0, 0, 21'h000001, 3'd3, 4'h8, 3'd0, 0, 32'h0000_0800, 0);
    applyStimulus(0, 0, 21'h00003F, 3'd4, 4'h8, 3'd0, 0, 32'h0000_001F, 0);
    applyStimulus(0, 9, 21'h000000, 3'd5, 4'h8, 3'd0, 0, 32'h0, 0);
    applyStimulus(32'h8000_0000, 0, 21'd4, 3'd4, 4'hC, 3'd0, 0, 32'hF800_0000, 0);
    applyStimulus(32'h8000_0000, 0, 21'd4, 3'd4, 4'hB, 3'd0, 0, 32'h0800_0000, 0);
    applyStimulus(32'h0000_0001, 0, 21'd0, 3'd4, 4'hA, 3'd0, 0, 32'h0000_0001, 0);
    applyStimulus(32'h0000_0001, 0, 21'd3, 3'd4, 4'hA, 3'd0, 0, 32'h0000_0008, 0);
    applyStimulus(3, 5, 0, 3'd0, 4'h3, 3'd0, 0, 32'd2, 0);
    applyStimulus(32'hF0, 32'h3C, 0, 3'd0, 4'h7, 3'd0, 0, 32'hC0, 0);
    applyStimulus(32'hF0, 32'h3C, 0, 3'd0, 4'h6, 3'd0, 0, 32'hCC, 0);
    applyStimulus(3, 5, 0, 3'd0, 4'h2, 3'd4, 1, 32'h3C, 1);
    applyStimulus(5, 3, 0, 3'd0, 4'h2, 3'd4, 1, 32'h3C, 0);
    applyStimulus(32'h7FFF_FFFF, 1, 0, 3'd0, 4'h0, 3'd6, 1, 32'h3C, 1);
    applyStimulus(3, 5, 0, 3'd0, 4'h2, 3'd2, 1, 32'h3C, 1);
    applyStimulus(5, 5, 0, 3'd0, 4'h2, 3'd3, 1, 32'h3C, 1);
    applyStimulus(1, 0, 0, 3'd0, 4'h9, 3'd7, 1, 32'h3C, 1);
    applyStimulus(5, 5, 0, 3'd0, 4'h2, 3'd0, 1, 32'h3C, 0);
    applyStimulus(32'h8000_0000, 1, 0, 3'd0, 4'h2, 3'd6, 1, 32'h3C, 1);

    // Async reset mid-run clears the pipeline register and PSW.C
    clearInputs();
    FPA = 32'hFFFF_FFFF; FPB = 2; PSW_LE_RE = 2'b10; IDR = 7; RF_LE = 1; L = 1; RAM_CTRL = 4'h5;
    step();
    checkOutput("pre_EX_OUT_Q", EX_OUT_Q, 32'h1);
    checkOutput("pre_EX_DI_Q", EX_DI_Q, 32'h2);
    checkOutput("pre_RAM_Q", 32'(RAM_CTRL_Q), 32'h5);
    clearInputs();
    RST = 1'b0;
    #1;
    checkOutput("ar_EX_OUT_Q", EX_OUT_Q, 32'h0);
    checkOutput("ar_EX_DI_Q", EX_DI_Q, 32'h0);
    checkOutput("ar_EX_RD_Q", 32'(EX_RD_Q), 32'h0);
    checkOutput("ar_L_Q", 32'(L_Q), 32'h0);
    checkOutput("ar_RF_LE_Q", 32'(RF_LE_Q), 32'h0);
    checkOutput("ar_RAM_Q", 32'(RAM_CTRL_Q), 32'h0);
    RST = 1'b1;
    ALU_OP = 4'b0001; PSW_LE_RE = 2'b01;
    #1 checkOutput("ar_pswC", EX_OUT, 32'h0);
    step();
    step();

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_hazard_stage.md
# ex_hazard_stage

This block combines the execute stage, the EX/MEM pipeline register and the data-hazard/forwarding unit of the 5-stage PA-RISC-subset pipeline. It sits between the ID/EX register and the MEM stage. It resolves operands and branches, latches results for MEM, and drives the stall and forward-select controls back to IF/ID.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- RET_ADDR  in  8  link (return) address
- TA_IN  in  8  branch target address
- FPA, FPB  in  32  forwarded operands A/B
- IM  in  21  raw immediate field
- COND  in  3  branch condition
- IDR  in  5  destination register
- PSW_LE_RE  in  2  [1]=PSW carry load enable, [0]=PSW carry read enable
- B, UB  in  1  conditional / unconditional branch
- SOH_OP  in  3  second-operand select
- ALU_OP  in  4  ALU function
- RAM_CTRL  in  4  memory control, passed through
- L, RF_LE  in  1  load select / register-file write enable
- RA, RB  in  5  ID source registers
- ID_SR  in  2  [0]=RA used, [1]=RB used
- WB_RD  in  5, WB_RF_LE  in  1  writeback destination and enable
- EX_J  out  1  taken branch/jump (IF select, IF/ID clear)
- TARGET_ADDRESS  out  8  =TA_IN
- EX_OUT  out  32  combinational EX result (forward path)
- EX_OUT_Q, EX_DI_Q  out  32  registered result / store data
- EX_RD_Q  out  5, L_Q, RF_LE_Q  out  1, RAM_CTRL_Q  out  4  registered controls
- NOP  out  1  insert bubble in ID
- LE  out  1  PC and IF/ID load enable
- A_S, B_S  out  2  forward select: 00 reg file, 01 EX, 10 MEM, 11 WB

## Operation
- Operand B is selected by SOH_OP:
  - 000 FPB
  - 001 sign-extend IM[10:0]
  - 010 sign-extend IM[13:0]
  - 011 {IM[20:0],11'b0}
  - 100 zero-extend IM[4:0]
  - others 0
- ALU, A=FPA:
  - 0000 A+B
  - 0001 A+B+Cin
  - 0010 A−B
  - 0011 B−A
  - 0100 A&B
  - 0101 A|B
  - 0110 A^B
  - 0111 A&~B
  - 1000 B
  - 1001 A
  - 1010 A<<B[4:0]
  - 1011 A>>B[4:0] logical
  - 1100 arithmetic shift right
  - others 0
- Cin = PSW.C when PSW_LE_RE[0], else 0.
- Flags Z, N, C and V come from 32-bit arithmetic. For subtract, C=1 means no borrow. Logic and shift operations give C=V=0.
- Conditions:
  - 000 never
  - 001 Z
  - 010 N^V
  - 011 (N^V)|Z
  - 100 ~C
  - 101 ~C|Z
  - 110 V
  - 111 result[0]
- EX_J = UB | (B & cond).
- EX_OUT = {24'b0,RET_ADDR} when UB or B, otherwise the ALU result.
- EX_DI = FPB.
- DHDU register-file sources:
  - EX source: IDR / RF_LE.
  - MEM source: EX_RD_Q / RF_LE_Q.
  - WB source: WB_RD / WB_RF_LE.
  - A source matches when the stage's enable is set, its RD==RA and RA≠0.
- Forward-select priority is EX > MEM > WB > 00. B_S follows the same rule with RB.
- Load-use stall is taken when L & RF_LE & IDR≠0 & ((ID_SR[0] & RA==IDR) | (ID_SR[1] & RB==IDR)). It gives NOP=1, LE=0; otherwise NOP=0, LE=1.
- A_S and B_S are computed regardless of ID_SR.

## Timing
- EX_J, TARGET_ADDRESS, EX_OUT, NOP, LE, A_S and B_S are purely combinational, with zero latency.
- On the CLK rising edge:
  - The Q outputs capture EX_OUT, FPB, IDR, L, RF_LE and RAM_CTRL.
  - PSW.C captures the ALU carry when PSW_LE_RE[1]=1.
- RST low clears all Q outputs and PSW.C to 0 immediately, regardless of CLK. This also applies mid-run.
- During and after reset, RF_LE_Q=0, so no MEM forwarding occurs.
- Shift amounts of 0 pass A unchanged. Add wraps modulo 2^32.
- Simultaneous stall and forward: both are asserted. The stalled instruction re-evaluates next cycle, and the bubble then has RF_LE=0.
- There is one cycle of EX→MEM latency for registered outputs.

## Test plan
- Add: FPA=5, FPB=3, SOH 000, ALU 0000, IDR=3, RF_LE=1 -> EX_OUT=8; after the edge, EX_OUT_Q=8, EX_RD_Q=3, RF_LE_Q=1.
- Branch: B=1, COND 001, ALU 0010, FPA=FPB=7, TA_IN=0x20 -> EX_J=1, TARGET_ADDRESS=0x20. With FPB=6 -> EX_J=0. UB=1, RET_ADDR=0x14 -> EX_J=1, EX_OUT=0x14.
- Forward priority: RA=2, IDR=2/RF_LE=1, EX_RD_Q=2/RF_LE_Q=1, WB_RD=2/WB_RF_LE=1 -> A_S=01. Then:
  - Clear RF_LE -> 10.
  - Flush MEM -> 11.
  - RA=0 -> 00.
- Load-use: L=1, RF_LE=1, IDR=4, RB=4, ID_SR=10 -> NOP=1, LE=0, B_S=01. With ID_SR=00 -> NOP=0, LE=1.
- Carry chain: FPA=0xFFFFFFFF, FPB=1, ALU 0000, PSW_LE_RE=10 -> EX_OUT=0, PSW.C=1 after the edge. Next, FPA=FPB=0, ALU 0001, PSW_LE_RE=01 -> EX_OUT=1.
- Async reset: capture nonzero values, then drive RST=0 between edges -> all Q outputs and PSW.C are 0 immediately.
